// File: rtl/mem_pkg.sv
// Shared MEM-stage encodings: access width, rd source, writeback error codes, FSM state,
// plus the byte-enable / store-lane helpers used by the stage.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    DIGIT_WORD = 2'b00,
    DIGIT_HALF = 2'b01,
    DIGIT_BYTE = 2'b10,
    DIGIT_RSVD = 2'b11
  } digit_e;

  typedef enum logic [1:0] {
    RD_ALU  = 2'b00,
    RD_LOAD = 2'b01,
    RD_PC4  = 2'b10,
    RD_CMP  = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ERR_NONE     = 2'b00,
    WB_ERR_MISALIGN = 2'b01,
    WB_ERR_TIMEOUT  = 2'b10
  } wb_err_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             regwr;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic [1:0]       err;
    logic [XLEN-1:0]  pc;
  } wb_t;

  // Reserved width behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] digit, input logic [1:0] off);
    case (digit)
      DIGIT_HALF: return off[0];
      DIGIT_BYTE: return 1'b0;
      default:    return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] digit, input logic [1:0] off);
    case (digit)
      DIGIT_HALF: return off[1] ? 4'b1100 : 4'b0011;
      DIGIT_BYTE: return 4'b0001 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_align(input logic [1:0] digit, input logic [XLEN-1:0] sd);
    case (digit)
      DIGIT_HALF: return {2{sd[15:0]}};
      DIGIT_BYTE: return {4{sd[7:0]}};
      default:    return sd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load extractor: selects the addressed byte/half lane of the read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      digit_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] data_c_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (off_i)
      2'b00:   byte_lane = rdata_i[7:0];
      2'b01:   byte_lane = rdata_i[15:8];
      2'b10:   byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (digit_i)
      DIGIT_BYTE: data_c_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
      DIGIT_HALF: data_c_o = {{16{sign_i & half_lane[15]}}, half_lane};
      default:    data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over a req/ack handshake with timeout,
// store alignment, load extraction, writeback select and the MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       RegDstIn,
  input  logic             RegWrIn,
  input  logic [1:0]       DigitIn,
  input  logic             DataWrIn,
  input  logic             immresIn,
  input  logic [1:0]       cmpIn,
  input  logic             SignIn,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [REG_W-1:0] rd_in,
  input  logic [XLEN-1:0]  pc_in,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  output logic [3:0]       mem_wea,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             stall,
  output logic             wb_valid,
  output logic             wb_RegWr,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [1:0]       wb_err,
  output logic [XLEN-1:0]  wb_pc
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [3:0]       wea_q, wea_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  wb_t              wb_q, wb_d;

  logic             memop_c;
  logic             misalign_c;
  logic             timeout_c;
  logic [XLEN-1:0]  load_c;
  logic [XLEN-1:0]  result_c;

  assign memop_c    = valid_in && (DataWrIn || (RegDstIn == RD_LOAD));
  assign misalign_c = is_misaligned(DigitIn, alu_res[1:0]);
  assign timeout_c  = (state_q == ST_ACCESS) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Upstream is held by stall, so the live inputs stay valid for the whole access.
  assign stall = ((state_q == ST_IDLE) && memop_c && !misalign_c) ||
                 ((state_q == ST_ACCESS) && !mem_ack && !timeout_c);

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .off_i    (alu_res[1:0]),
    .digit_i  (DigitIn),
    .sign_i   (SignIn),
    .data_c_o (load_c)
  );

  // Writeback value select.
  always_comb begin
    result_c = alu_res;
    if (immresIn) begin
      result_c = imm;
    end else begin
      case (RegDstIn)
        RD_LOAD: result_c = load_c;
        RD_PC4:  result_c = pc_in + XLEN'(4);
        RD_CMP:  result_c = {30'b0, cmpIn};
        default: result_c = alu_res;
      endcase
    end
  end

  // Next-state and MEM/WB capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wea_d     = wea_q;
    wdata_d   = wdata_q;
    wb_d      = wb_q;
    wb_d.valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (memop_c && !misalign_c) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          addr_d  = {alu_res[XLEN-1:2], 2'b00};
          wea_d   = DataWrIn ? byte_en(DigitIn, alu_res[1:0]) : 4'b0000;
          wdata_d = store_align(DigitIn, store_data);
        end else if (memop_c) begin
          wb_d = '{valid: 1'b1, regwr: 1'b0, rd: rd_in, data: '0,
                   err: WB_ERR_MISALIGN, pc: pc_in};
        end else if (valid_in) begin
          wb_d = '{valid: 1'b1, regwr: RegWrIn, rd: rd_in, data: result_c,
                   err: WB_ERR_NONE, pc: pc_in};
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          wb_d = '{valid: 1'b1, regwr: RegWrIn, rd: rd_in, data: result_c,
                   err: WB_ERR_NONE, pc: pc_in};
        end else if (timeout_c) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          wb_d = '{valid: 1'b1, regwr: 1'b0, rd: rd_in, data: '0,
                   err: WB_ERR_TIMEOUT, pc: pc_in};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline registers update on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wea_q   <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wea_q   <= wea_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wea   = wea_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_q.valid;
  assign wb_RegWr  = wb_q.regwr;
  assign wb_rd     = wb_q.rd;
  assign wb_data   = wb_q.data;
  assign wb_err    = wb_q.err;
  assign wb_pc     = wb_q.pc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized instructions against a
// rule-level model, and reset-during-access sequences.
module tb_mem_access_stage;

  localparam int TP = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  RegDstIn;
  logic        RegWrIn;
  logic [1:0]  DigitIn;
  logic        DataWrIn;
  logic        immresIn;
  logic [1:0]  cmpIn;
  logic        SignIn;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic [31:0] imm;
  logic [4:0]  rd_in;
  logic [31:0] pc_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wea;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        wb_valid;
  logic        wb_RegWr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_err;
  logic [31:0] wb_pc;

  int tests_run;
  int tests_failed;

  mem_access_stage #(.TIMEOUT(TP)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .RegDstIn(RegDstIn),
    .RegWrIn(RegWrIn), .DigitIn(DigitIn), .DataWrIn(DataWrIn), .immresIn(immresIn),
    .cmpIn(cmpIn), .SignIn(SignIn), .alu_res(alu_res), .store_data(store_data),
    .imm(imm), .rd_in(rd_in), .pc_in(pc_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wea(mem_wea), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_valid(wb_valid), .wb_RegWr(wb_RegWr), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .wb_pc(wb_pc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [1:0]  regdst;
    logic        regwr;
    logic [1:0]  digit;
    logic        datawr;
    logic        immres;
    logic [1:0]  cmp;
    logic        sign;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          ack_dly;
    logic        e_req;
    logic [3:0]  e_wea;
    logic [31:0] e_wdata;
    logic [1:0]  e_err;
    logic        e_regwr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[15];
  int   ntbl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic valid, input logic [1:0] regdst, input logic regwr,
                     input logic [1:0] digit, input logic datawr, input logic immres,
                     input logic [1:0] cmp, input logic sign, input logic [31:0] alu,
                     input logic [31:0] sd, input logic [31:0] im, input logic [4:0] rd,
                     input logic [31:0] pc, input logic [31:0] rdata, input int ack,
                     input logic e_req, input logic [3:0] e_wea, input logic [31:0] e_wdata,
                     input logic [1:0] e_err, input logic e_regwr, input logic [31:0] e_data);
    vec_t v;
    v.valid = valid; v.regdst = regdst; v.regwr = regwr; v.digit = digit;
    v.datawr = datawr; v.immres = immres; v.cmp = cmp; v.sign = sign;
    v.alu = alu; v.sd = sd; v.imm = im; v.rd = rd; v.pc = pc; v.rdata = rdata;
    v.ack_dly = ack; v.e_req = e_req; v.e_wea = e_wea; v.e_wdata = e_wdata;
    v.e_err = e_err; v.e_regwr = e_regwr; v.e_data = e_data;
    tbl[ntbl] = v;
    ntbl++;
  endtask

  // Rule-level reference: expected request, lanes and retire values for one instruction.
  function automatic vec_t model(input vec_t v);
    int a;
    bit memop, mis, tmo;
    logic [31:0] ld, val;
    a = int'(v.alu[1:0]);
    memop = v.valid && (v.datawr || v.regdst == 2'd1);
    mis = (v.digit == 2'd1 && (a % 2) != 0) || ((v.digit == 2'd0 || v.digit == 2'd3) && a != 0);
    v.e_req = memop && !mis;
    v.e_wea = 4'h0;
    if (v.e_req && v.datawr) begin
      if (v.digit == 2'd2)      v.e_wea = 4'(1 << a);
      else if (v.digit == 2'd1) v.e_wea = (a >= 2) ? 4'hC : 4'h3;
      else                      v.e_wea = 4'hF;
    end
    if (v.digit == 2'd2)      v.e_wdata = {24'h0, v.sd[7:0]} * 32'h01010101;
    else if (v.digit == 2'd1) v.e_wdata = {16'h0, v.sd[15:0]} * 32'h00010001;
    else                      v.e_wdata = v.sd;
    if (v.digit == 2'd2) begin
      ld = (v.rdata >> (8 * a)) & 32'hFF;
      if (v.sign && ld >= 32'd128) ld = ld - 32'd256;
    end else if (v.digit == 2'd1) begin
      ld = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
      if (v.sign && ld >= 32'd32768) ld = ld - 32'd65536;
    end else begin
      ld = v.rdata;
    end
    if (v.immres)               val = v.imm;
    else if (v.regdst == 2'd0)  val = v.alu;
    else if (v.regdst == 2'd1)  val = ld;
    else if (v.regdst == 2'd2)  val = v.pc + 32'd4;
    else                        val = {30'h0, v.cmp};
    tmo = v.e_req && (v.ack_dly >= TP);
    v.e_err   = (memop && mis) ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    v.e_regwr = (v.e_err == 2'd0) && v.regwr;
    v.e_data  = (v.e_err == 2'd0) ? val : 32'h0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    valid_in = v.valid; RegDstIn = v.regdst; RegWrIn = v.regwr; DigitIn = v.digit;
    DataWrIn = v.datawr; immresIn = v.immres; cmpIn = v.cmp; SignIn = v.sign;
    alu_res = v.alu; store_data = v.sd; imm = v.imm; rd_in = v.rd; pc_in = v.pc;
  endtask

  // Applies one instruction, holds it while stalled, plays the memory side, checks the retire.
  task automatic run_vec(input vec_t v);
    int  stall_n, req_n, exp_stall, exp_req;
    bit  done;
    drive(v);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    #1;
    stall_n = 0;
    req_n = 0;
    if (stall) stall_n++;
    chk("stall_first_cycle", 32'(stall), 32'(v.e_req));
    @(negedge clk); #1;
    if (v.e_req) begin
      chk("mem_req_issued", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, v.alu & 32'hFFFF_FFFC);
      chk("mem_wea", 32'(mem_wea), 32'(v.e_wea));
      if (v.datawr) chk("mem_wdata", mem_wdata, v.e_wdata);
      chk("wb_bubble_on_request", 32'(wb_valid), 32'd0);
      done = 1'b0;
      for (int k = 0; k < TP && !done; k++) begin
        if (mem_req) req_n++;
        mem_rdata = $urandom;
        if (k == v.ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        #1;
        if (stall) stall_n++;
        if (k == v.ack_dly || k == TP - 1) done = 1'b1;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        if (!done) chk("wb_bubble_while_waiting", 32'(wb_valid), 32'd0);
      end
    end
    exp_stall = v.e_req ? 1 + ((v.ack_dly < TP - 1) ? v.ack_dly : TP - 1) : 0;
    exp_req   = v.e_req ? ((v.ack_dly < TP) ? v.ack_dly + 1 : TP) : 0;
    chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
    chk("mem_req_cycles", 32'(req_n), 32'(exp_req));
    chk("wb_valid", 32'(wb_valid), 32'(v.valid));
    if (v.valid) begin
      chk("wb_err", 32'(wb_err), 32'(v.e_err));
      chk("wb_RegWr", 32'(wb_RegWr), 32'(v.e_regwr));
      chk("wb_data", wb_data, v.e_data);
      chk("wb_rd", 32'(wb_rd), 32'(v.rd));
      chk("wb_pc", wb_pc, v.pc);
    end
    chk("mem_req_after_retire", 32'(mem_req), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wea"}, 32'(mem_wea), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_RegWr"}, 32'(wb_RegWr), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_err"}, 32'(wb_err), 32'd0);
    chk({tag, "_wb_pc"}, wb_pc, 32'd0);
  endtask

  vec_t rv;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    ntbl = 0;
    rst_n = 1'b0;
    valid_in = 0; RegDstIn = 0; RegWrIn = 0; DigitIn = 0; DataWrIn = 0; immresIn = 0;
    cmpIn = 0; SignIn = 0; alu_res = 0; store_data = 0; imm = 0; rd_in = 0; pc_in = 0;
    mem_rdata = 0; mem_ack = 0;

    //  v  rdst  rw digit dw im cmp sg  alu        sd           imm        rd     pc         rdata        ack  req wea    wdata         err  rw  data
    add(1, 2'd1, 1, 2'd2, 0, 0, 2'd0, 1, 32'h103, 32'h0,        32'h0,    5'd3,  32'h100, 32'h80000000, 1,  1, 4'h0, 32'h0,        2'd0, 1, 32'hFFFFFF80);
    add(1, 2'd0, 0, 2'd1, 1, 0, 2'd0, 0, 32'h202, 32'h0000BEEF, 32'h0,    5'd0,  32'h104, 32'h0,        0,  1, 4'hC, 32'hBEEFBEEF, 2'd0, 0, 32'h202);
    add(1, 2'd1, 1, 2'd0, 0, 0, 2'd0, 0, 32'h101, 32'h0,        32'h0,    5'd4,  32'h108, 32'h0,        0,  0, 4'h0, 32'h0,        2'd1, 0, 32'h0);
    add(1, 2'd1, 1, 2'd0, 0, 0, 2'd0, 0, 32'h200, 32'h0,        32'h0,    5'd6,  32'h10C, 32'h0,        99, 1, 4'h0, 32'h0,        2'd2, 0, 32'h0);
    add(1, 2'd0, 1, 2'd0, 0, 1, 2'd0, 0, 32'h55,  32'h0,        32'h1234, 5'd5,  32'h110, 32'h0,        0,  0, 4'h0, 32'h0,        2'd0, 1, 32'h1234);
    add(1, 2'd2, 1, 2'd0, 0, 0, 2'd0, 0, 32'h77,  32'h0,        32'h0,    5'd31, 32'h400, 32'h0,        0,  0, 4'h0, 32'h0,        2'd0, 1, 32'h404);
    add(1, 2'd3, 1, 2'd0, 0, 0, 2'd2, 0, 32'h77,  32'h0,        32'h0,    5'd7,  32'h114, 32'h0,        0,  0, 4'h0, 32'h0,        2'd0, 1, 32'h2);
    add(1, 2'd1, 1, 2'd2, 0, 0, 2'd0, 0, 32'h102, 32'h0,        32'h0,    5'd8,  32'h118, 32'h12AB3456, 0,  1, 4'h0, 32'h0,        2'd0, 1, 32'hAB);
    add(1, 2'd1, 1, 2'd1, 0, 0, 2'd0, 1, 32'h302, 32'h0,        32'h0,    5'd9,  32'h11C, 32'h80017FFF, 2,  1, 4'h0, 32'h0,        2'd0, 1, 32'hFFFF8001);
    add(1, 2'd0, 0, 2'd2, 1, 0, 2'd0, 0, 32'h3,   32'h11223344, 32'h0,    5'd0,  32'h120, 32'h0,        0,  1, 4'h8, 32'h44444444, 2'd0, 0, 32'h3);
    add(1, 2'd0, 0, 2'd3, 1, 0, 2'd0, 0, 32'h20,  32'hCAFEF00D, 32'h0,    5'd0,  32'h124, 32'h0,        1,  1, 4'hF, 32'hCAFEF00D, 2'd0, 0, 32'h20);
    add(0, 2'd1, 1, 2'd0, 0, 0, 2'd0, 0, 32'h1,   32'h0,        32'h0,    5'd2,  32'h128, 32'h0,        0,  0, 4'h0, 32'h0,        2'd0, 0, 32'h0);
    add(1, 2'd0, 0, 2'd1, 1, 0, 2'd0, 0, 32'h201, 32'h1,        32'h0,    5'd0,  32'h12C, 32'h0,        0,  0, 4'h0, 32'h0,        2'd1, 0, 32'h0);
    add(1, 2'd1, 1, 2'd0, 0, 0, 2'd0, 0, 32'h40,  32'h0,        32'h0,    5'd10, 32'h130, 32'hDEADBEEF, 3,  1, 4'h0, 32'h0,        2'd0, 1, 32'hDEADBEEF);
    add(1, 2'd1, 1, 2'd1, 0, 0, 2'd0, 0, 32'h300, 32'h0,        32'h0,    5'd11, 32'h134, 32'h1234F00D, 0,  1, 4'h0, 32'h0,        2'd0, 1, 32'hF00D);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < ntbl; i++) run_vec(tbl[i]);

    for (int n = 0; n < 80; n++) begin
      rv.valid   = ($urandom_range(0, 9) != 0);
      rv.regdst  = 2'($urandom_range(0, 3));
      rv.regwr   = 1'($urandom_range(0, 1));
      rv.digit   = 2'($urandom_range(0, 3));
      rv.datawr  = ($urandom_range(0, 2) == 0);
      rv.immres  = ($urandom_range(0, 4) == 0);
      rv.cmp     = 2'($urandom_range(0, 3));
      rv.sign    = 1'($urandom_range(0, 1));
      rv.alu     = {20'h0, 12'($urandom)};
      rv.sd      = $urandom;
      rv.imm     = $urandom;
      rv.rd      = 5'($urandom);
      rv.pc      = {$urandom} & 32'hFFFF_FFFC;
      rv.rdata   = $urandom;
      rv.ack_dly = $urandom_range(0, 5);
      rv = model(rv);
      run_vec(rv);
    end

    // Reset in the middle of an access, then a late ack.
    run_vec(tbl[0]);
    drive(tbl[13]);
    mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("rst_seq_req_up", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    valid_in = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("rst_in_access");
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555AAAA;
    #1;
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(negedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_wb_data", wb_data, 32'd0);

    // Counter restarts from zero after reset: full timeout window again.
    run_vec(tbl[3]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
